// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helper for the multi-depth FIFO
package fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 64;
  function automatic int clog2p1(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/multi_depth_fifo_if.sv
// multi_depth_fifo_if: write/read handshake, occupancy and error bundle
interface multi_depth_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
);
  localparam int CW = clog2p1(DEPTH);
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_inc;
  logic                  w_full;
  logic                  w_almost_full;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_inc;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic [CW-1:0]         count;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output w_data, w_inc, r_inc, err_clr,
    input  w_full, w_almost_full, r_data, r_empty, r_almost_empty, count, overflow, underflow
  );
  modport slave (
    input  w_data, w_inc, r_inc, err_clr,
    output w_full, w_almost_full, r_data, r_empty, r_almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: wrap-around pointers, occupancy count, status and sticky error flags
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH               = 4,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESH = 1,
  parameter int PW                  = $clog2(DEPTH),
  parameter int CW                  = clog2p1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_inc,
  input  logic          r_inc,
  input  logic          err_clr,
  output logic          w_en,
  output logic          r_en,
  output logic [PW-1:0] w_ptr,
  output logic [PW-1:0] r_ptr,
  output logic [CW-1:0] count,
  output logic          w_full,
  output logic          w_almost_full,
  output logic          r_empty,
  output logic          r_almost_empty,
  output logic          overflow,
  output logic          underflow
);
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // flags come from the registered count only, so read and write accepts never depend on each other
  always_comb begin
    w_full         = count == CW'(DEPTH);
    r_empty        = count == '0;
    w_almost_full  = 32'(count) >= ALMOST_FULL_THRESH;
    r_almost_empty = 32'(count) <= ALMOST_EMPTY_THRESH;
    w_en           = w_inc && !w_full;
    r_en           = r_inc && !r_empty;
  end
  // pointers advance on accepted operations and wrap at DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (w_en) w_ptr <= wrap_inc(w_ptr);
      if (r_en) r_ptr <= wrap_inc(r_ptr);
    end
  end
  // occupancy holds when both or neither operation is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (w_en != r_en) count <= w_en ? count + 1'b1 : count - 1'b1;
  end
  // sticky errors; a new error in the clearing cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_inc && w_full) || (overflow && !err_clr);
      underflow <= (r_inc && r_empty) || (underflow && !err_clr);
    end
  end
endmodule

// File: rtl/multi_depth_fifo.sv
// multi_depth_fifo: parametrised synchronous FIFO with show-ahead or registered read
module multi_depth_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  parameter int DEPTH               = 4,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESH = 1,
  parameter bit SHOW_AHEAD          = 1'b1
) (
  input logic               clk,
  input logic               rst,
  multi_depth_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic                  w_en;
  logic                  r_en;
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  fifo_ptr_ctrl #(
    .DEPTH              (DEPTH),
    .ALMOST_FULL_THRESH (ALMOST_FULL_THRESH),
    .ALMOST_EMPTY_THRESH(ALMOST_EMPTY_THRESH)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .w_inc         (bus.w_inc),
    .r_inc         (bus.r_inc),
    .err_clr       (bus.err_clr),
    .w_en          (w_en),
    .r_en          (r_en),
    .w_ptr         (w_ptr),
    .r_ptr         (r_ptr),
    .count         (bus.count),
    .w_full        (bus.w_full),
    .w_almost_full (bus.w_almost_full),
    .r_empty       (bus.r_empty),
    .r_almost_empty(bus.r_almost_empty),
    .overflow      (bus.overflow),
    .underflow     (bus.underflow)
  );
  // storage is not reset; writes are blocked while reset is held so nothing lands mid-reset
  always_ff @(posedge clk) begin
    if (w_en && !rst) mem[w_ptr] <= bus.w_data;
  end
  // registered read data, loaded only on an accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else if (r_en) rd_q <= mem[r_ptr];
  end
  assign bus.r_data = SHOW_AHEAD ? mem[r_ptr] : rd_q;
endmodule

// File: tb/tb_multi_depth_fifo.sv
// tb_multi_depth_fifo: shared random/directed stimulus into several FIFO configurations, queue-model scoreboards
module tb_multi_depth_fifo;
  import fifo_pkg::*;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int DEPTHS [N] = '{4, 3, 5, 2};
  localparam int SAS    [N] = '{1, 1, 0, 0};
  localparam int AFS    [N] = '{3, 2, 4, 0};
  localparam int AES    [N] = '{1, 1, 2, 0};
  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [DW-1:0] w_data  = '0;
  logic          w_inc   = 1'b0;
  logic          r_inc   = 1'b0;
  logic          err_clr = 1'b0;
  int n_cmp  = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[cfg%0d] t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask
  for (genvar g = 0; g < N; g++) begin : u
    localparam int D = DEPTHS[g];
    multi_depth_fifo_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();
    assign bus.w_data  = w_data;
    assign bus.w_inc   = w_inc;
    assign bus.r_inc   = r_inc;
    assign bus.err_clr = err_clr;
    multi_depth_fifo #(
      .DATA_WIDTH         (DW),
      .DEPTH              (D),
      .ALMOST_FULL_THRESH (AFS[g]),
      .ALMOST_EMPTY_THRESH(AES[g]),
      .SHOW_AHEAD         (SAS[g] != 0)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    logic [DW-1:0] q [$];
    logic [DW-1:0] sb [$];
    logic          ov = 1'b0;
    logic          un = 1'b0;
    logic          rd_prev = 1'b0;
    logic [DW-1:0] last = '0;
    // reference model: contents as a plain queue, accept rules from occupancy
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        sb.delete();
        ov = 1'b0;
        un = 1'b0;
      end else begin
        automatic bit full  = q.size() == D;
        automatic bit empty = q.size() == 0;
        ov = (w_inc && full) ? 1'b1 : err_clr ? 1'b0 : ov;
        un = (r_inc && empty) ? 1'b1 : err_clr ? 1'b0 : un;
        if (r_inc && !empty) void'(q.pop_front());
        if (w_inc && !full) q.push_back(w_data);
      end
    end
    // expected read data is queued when a read that will be accepted is issued
    initial forever begin
      @(posedge clk);
      #2;
      if (!rst && r_inc && q.size() != 0) sb.push_back(q[0]);
    end
    // monitor: status every cycle, data whenever the DUT presents an accepted read
    initial forever begin
      @(negedge clk);
      chk("count", g, 64'(bus.count), 64'(q.size()));
      chk("r_empty", g, 64'(bus.r_empty), 64'(q.size() == 0));
      chk("w_full", g, 64'(bus.w_full), 64'(q.size() == D));
      chk("w_almost_full", g, 64'(bus.w_almost_full), 64'(q.size() >= AFS[g]));
      chk("r_almost_empty", g, 64'(bus.r_almost_empty), 64'(q.size() <= AES[g]));
      chk("overflow", g, 64'(bus.overflow), 64'(ov));
      chk("underflow", g, 64'(bus.underflow), 64'(un));
      if (SAS[g] != 0) begin
        if (!rst && r_inc && !bus.r_empty) begin
          if (sb.size() == 0) chk("sb_underrun", g, 64'(1), 64'(0));
          else chk("r_data_sa", g, 64'(bus.r_data), 64'(sb.pop_front()));
        end
      end else begin
        if (rst) begin
          rd_prev = 1'b0;
          last = '0;
        end else if (rd_prev) begin
          if (sb.size() == 0) chk("sb_underrun", g, 64'(1), 64'(0));
          else last = sb.pop_front();
        end
        chk("r_data_reg", g, 64'(bus.r_data), 64'(last));
        rd_prev = !rst && r_inc && !bus.r_empty;
      end
    end
  end
  task automatic step(input logic wi, input logic ri, input logic ec, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    w_inc = wi;
    r_inc = ri;
    err_clr = ec;
    w_data = wd;
  endtask
  task automatic mid_reset();
    @(posedge clk);
    #1;
    w_inc = 1'b0;
    r_inc = 1'b0;
    err_clr = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  // {w_inc, r_inc, err_clr, data}
  logic [18:0] dir [$] = '{
    19'h40011, 19'h40022, 19'h40033, 19'h40044, 19'h00000,
    19'h20000, 19'h20000, 19'h20000, 19'h20000, 19'h00000,
    19'h400A0, 19'h400A1, 19'h400A2, 19'h400A3, 19'h400A4,
    19'h60055, 19'h00000, 19'h10000, 19'h00000,
    19'h20000, 19'h20000, 19'h20000, 19'h20000, 19'h20000, 19'h20000,
    19'h10000, 19'h60077, 19'h00000, 19'h20000, 19'h00000,
    19'h4DEAD, 19'h20000, 19'h00000, 19'h00000, 19'h00000, 19'h10000,
    19'h600B0, 19'h600B1, 19'h600B2, 19'h600B3, 19'h600B4, 19'h600B5,
    19'h600B6, 19'h600B7, 19'h600B8, 19'h600B9, 19'h20000, 19'h20000,
    19'h40001, 19'h40002
  };
  initial begin
    int pw = 50;
    int pr = 50;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    foreach (dir[i]) begin
      logic [18:0] d;
      d = dir[i];
      step(d[18], d[17], d[16], d[15:0]);
    end
    mid_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        pw = 15 + 35 * $urandom_range(0, 2);
        pr = 15 + 35 * $urandom_range(0, 2);
      end
      if ($urandom_range(0, 399) == 0) mid_reset();
      else step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, $urandom_range(0, 19) == 0, DW'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_depth_fifo.md
Name: multi_depth_fifo

Overview:
Parametrised synchronous FIFO, next generation of the single-entry buffering cell. Used for inter-stage buffering in the pipeline and in bus bridges.
- Any depth >= 2 and any data width.
- Adds occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Selectable show-ahead (first-word-fall-through) or registered-read mode.

Parameters:
DataWidth, 64, width of each entry in bits
Depth, 4, number of entries; any integer >= 2, not required to be a power of two
AlmostFullThresh, Depth-1, WAlmostFull asserts when Count >= this value
AlmostEmptyThresh, 1, RAlmostEmpty asserts when Count <= this value
ShowAhead, 1, 1 = head entry visible on RData while !REmpty; 0 = RData registered, valid one cycle after an accepted read

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  asynchronous, active-high reset
WData  input  DataWidth  write data
WInc  input  1  write request
WFull  output  1  FIFO holds Depth entries
WAlmostFull  output  1  Count >= AlmostFullThresh
RData  output  DataWidth  read data (timing per ShowAhead)
RInc  input  1  read request
REmpty  output  1  FIFO holds 0 entries
RAlmostEmpty  output  1  Count <= AlmostEmptyThresh
Count  output  $clog2(Depth+1)  current occupancy, 0..Depth
ErrClr  input  1  clears sticky error flags
Overflow  output  1  sticky: a write was attempted while full
Underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (Rst high, async): write and read pointers = 0, Count = 0, Overflow = Underflow = 0, RData register = 0.
  - Outputs during reset: REmpty = 1, RAlmostEmpty = 1, WFull = 0, WAlmostFull = (AlmostFullThresh == 0).
  - Memory array is not reset.
- Accept rules:
  - Write accepted iff WInc && !WFull.
  - Read accepted iff RInc && !REmpty.
  - Flags are evaluated on registered state only; no combinational path from RInc to the write accept, or the reverse.
- Full with WInc and RInc in the same cycle: read accepted, write rejected, Overflow set. Count becomes Depth-1.
- Empty with WInc and RInc in the same cycle: write accepted, read rejected, Underflow set. Count becomes 1.
- Both accepted in the same cycle: both pointers advance, Count unchanged.
- Pointers: range 0..Depth-1. An increment from Depth-1 wraps to 0; explicit compare, not modulo 2^n.
- Count: +1 on write only, -1 on read only, else hold. WFull = (Count == Depth); REmpty = (Count == 0). All flags are derived combinationally from the registered Count.
- Write latency: data written at edge N is visible (ShowAhead=1) or readable (ShowAhead=0) from cycle N+1. No same-cycle bypass.
- ShowAhead=1: RData = mem[rd_ptr] combinationally. Value is undefined-but-stable while REmpty; the bench must not check it then.
- ShowAhead=0: on an accepted read, the RData register loads mem[rd_ptr] at that edge. Otherwise RData holds its last value.
- Error flags:
  - Overflow sets on WInc && WFull; Underflow sets on RInc && REmpty.
  - Both hold until ErrClr or Rst.
  - If ErrClr and a set condition occur in the same cycle, the set wins.
- Rejected operations never alter pointers, Count or memory.
- Rst asserted mid-stream: FIFO is immediately empty. Entries in flight are discarded; no partial update on release.

Decomposition:
- Shared package (fifo_pkg):
  - count-width function clog2p1(Depth);
  - default width constant DEFAULT_DATA_WIDTH = 64.
- One natural sub-module: fifo_ptr_ctrl, holding the wrap-around pointer, Count and flag logic. It is instantiated once.
- Memory array and RData register stay in the top module.

Test Plan:
- Depth=4, ShowAhead=1: write 0x11, 0x22, 0x33, 0x44 -> Count 1..4, WFull=1 after 4th edge, WAlmostFull=1 at Count=3. Then read 4 times -> RData 0x11, 0x22, 0x33, 0x44 in order, REmpty=1 at end.
- Depth=3 (non power of two): 10 interleaved write/read pairs of 0xA0+i -> every value returned in order across pointer wrap, Count never exceeds 3.
- Full plus simultaneous WInc/RInc with WData=0x55 -> read returns head, 0x55 not stored, Overflow=1, Count=Depth-1. ErrClr for 1 cycle -> Overflow=0.
- Empty plus simultaneous WInc/RInc with WData=0x77 -> Underflow=1, Count=1. Next cycle RData=0x77 (ShowAhead=1).
- ShowAhead=0: write 0xDEAD, then RInc at edge N -> RData=0xDEAD from cycle N+1 and held while no further read.
- Fill to 2 entries, assert Rst asynchronously mid-cycle -> REmpty=1, Count=0, Overflow=Underflow=0 immediately, before the next clock edge.
